// File: rtl/lfsr_stream_gen.sv
// W-bit LFSR sequence generator with Fibonacci/Galois feedback, seed load with
// all-zero lock-up recovery, and a valid/ready burst engine.
module lfsr_stream_gen #(
   parameter int unsigned   W      = 5,
   parameter logic [W-1:0]  TAPS_F = 5'b10100,
   parameter logic [W-1:0]  TAPS_G = 5'b00101,
   parameter logic [W-1:0]  SEED   = {W{1'b1}},
   parameter int unsigned   CW     = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [W-1:0]  seed_in,
   input  logic          mode,
   input  logic          start,
   input  logic [CW-1:0] len,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [W-1:0]  out_data,
   output logic          out_bit,
   output logic          busy,
   output logic          done,
   output logic          lockup,
   output logic          wrap
);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   logic          fsm_q,    fsm_d;
   logic [W-1:0]  state_q,  state_d;
   logic [W-1:0]  ref_q,    ref_d;
   logic          mode_q,   mode_d;
   logic [CW-1:0] rem_q,    rem_d;
   logic          done_q,   done_d;
   logic          wrap_q,   wrap_d;
   logic          lockup_q, lockup_d;

   logic [W-1:0]  next_fib;
   logic [W-1:0]  next_gal;
   logic [W-1:0]  next_state;

   always_comb begin
      next_fib   = {state_q[W-2:0], ^(state_q & TAPS_F)};
      next_gal   = {state_q[W-2:0], 1'b0} ^ ({W{state_q[W-1]}} & TAPS_G);
      next_state = mode_q ? next_gal : next_fib;
   end

   always_comb begin
      fsm_d    = fsm_q;
      state_d  = state_q;
      ref_d    = ref_q;
      mode_d   = mode_q;
      rem_d    = rem_q;
      done_d   = 1'b0;
      wrap_d   = 1'b0;
      lockup_d = lockup_q;

      case (fsm_q)
         ST_IDLE: begin
            // load takes priority over start; a zero seed would lock the LFSR
            if (load) begin
               if (seed_in == '0) begin
                  state_d  = SEED;
                  ref_d    = SEED;
                  lockup_d = 1'b1;
               end else begin
                  state_d  = seed_in;
                  ref_d    = seed_in;
                  lockup_d = 1'b0;
               end
            end else if (start && (len != '0)) begin
               mode_d = mode;
               rem_d  = len;
               fsm_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            if (out_ready) begin
               state_d = next_state;
               rem_d   = rem_q - CW'(1);
               wrap_d  = (next_state == ref_q);
               if (rem_q == CW'(1)) begin
                  fsm_d  = ST_IDLE;
                  done_d = 1'b1;
               end
            end
         end
         default: fsm_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q    <= ST_IDLE;
         state_q  <= SEED;
         ref_q    <= SEED;
         mode_q   <= 1'b0;
         rem_q    <= '0;
         done_q   <= 1'b0;
         wrap_q   <= 1'b0;
         lockup_q <= 1'b0;
      end else begin
         fsm_q    <= fsm_d;
         state_q  <= state_d;
         ref_q    <= ref_d;
         mode_q   <= mode_d;
         rem_q    <= rem_d;
         done_q   <= done_d;
         wrap_q   <= wrap_d;
         lockup_q <= lockup_d;
      end
   end

   assign out_valid = (fsm_q == ST_RUN);
   assign busy      = (fsm_q == ST_RUN);
   assign out_data  = state_q;
   assign out_bit   = state_q[W-1];
   assign done      = done_q;
   assign lockup    = lockup_q;
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// Directed bench for lfsr_stream_gen: per-cycle vector table plus hand-written
// full-period and mid-burst reset sequences.
module tb_lfsr_stream_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load = 1'b0;
   logic [4:0] seed_in = '0;
   logic       mode = 1'b0;
   logic       start = 1'b0;
   logic [7:0] len = '0;
   logic       out_ready = 1'b0;
   logic       out_valid;
   logic [4:0] out_data;
   logic       out_bit;
   logic       busy;
   logic       done;
   logic       lockup;
   logic       wrap;

   int tests = 0;
   int fails = 0;

   lfsr_stream_gen #(.W(5), .TAPS_F(5'b10100), .TAPS_G(5'b00101),
                     .SEED(5'b11111), .CW(8)) dut (
      .clk(clk), .rst(rst), .load(load), .seed_in(seed_in), .mode(mode),
      .start(start), .len(len), .out_ready(out_ready), .out_valid(out_valid),
      .out_data(out_data), .out_bit(out_bit), .busy(busy), .done(done),
      .lockup(lockup), .wrap(wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       load;
      logic [4:0] seed;
      logic       mode;
      logic       start;
      logic [7:0] len;
      logic       rdy;
      logic [4:0] e_data;
      logic       e_valid;
      logic       e_done;
      logic       e_lock;
   } vec_t;

   vec_t vt[34];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic ld, input logic [4:0] sd, input logic md,
                               input logic st, input logic [7:0] ln, input logic rd,
                               input logic [4:0] ed, input logic ev, input logic edn,
                               input logic el);
      vec_t v;
      v.load = ld; v.seed = sd; v.mode = md; v.start = st; v.len = ln; v.rdy = rd;
      v.e_data = ed; v.e_valid = ev; v.e_done = edn; v.e_lock = el;
      return v;
   endfunction

   function automatic logic [4:0] fib_ref(input logic [4:0] s);
      return {s[3:0], s[4] ^ s[2]};
   endfunction

   int wraps;
   int dones;
   logic [4:0] exp_s;

   initial begin
      // Fibonacci len=3 from reset seed
      vt[0]  = mk(0, 5'h00, 0, 1, 3, 1, 5'b11111, 1, 0, 0);
      vt[1]  = mk(0, 5'h00, 0, 0, 0, 1, 5'b11110, 1, 0, 0);
      vt[2]  = mk(0, 5'h00, 0, 0, 0, 1, 5'b11100, 1, 0, 0);
      vt[3]  = mk(0, 5'h00, 0, 0, 0, 1, 5'b11000, 0, 1, 0);
      vt[4]  = mk(0, 5'h00, 0, 0, 0, 1, 5'b11000, 0, 0, 0);
      // Load 00001, Galois len=6
      vt[5]  = mk(1, 5'b00001, 0, 0, 0, 1, 5'b00001, 0, 0, 0);
      vt[6]  = mk(0, 5'h00, 1, 1, 6, 1, 5'b00001, 1, 0, 0);
      vt[7]  = mk(0, 5'h00, 0, 0, 0, 1, 5'b00010, 1, 0, 0);
      vt[8]  = mk(0, 5'h00, 0, 0, 0, 1, 5'b00100, 1, 0, 0);
      vt[9]  = mk(0, 5'h00, 0, 0, 0, 1, 5'b01000, 1, 0, 0);
      vt[10] = mk(0, 5'h00, 0, 0, 0, 1, 5'b10000, 1, 0, 0);
      vt[11] = mk(0, 5'h00, 0, 0, 0, 1, 5'b00101, 1, 0, 0);
      vt[12] = mk(0, 5'h00, 0, 0, 0, 1, 5'b01010, 0, 1, 0);
      vt[13] = mk(0, 5'h00, 0, 0, 0, 1, 5'b01010, 0, 0, 0);
      // Backpressure: Fibonacci len=5, stall two cycles on word 2
      vt[14] = mk(1, 5'b11111, 0, 0, 0, 1, 5'b11111, 0, 0, 0);
      vt[15] = mk(0, 5'h00, 0, 1, 5, 1, 5'b11111, 1, 0, 0);
      vt[16] = mk(0, 5'h00, 0, 0, 0, 1, 5'b11110, 1, 0, 0);
      vt[17] = mk(0, 5'h00, 0, 0, 0, 0, 5'b11110, 1, 0, 0);
      vt[18] = mk(0, 5'h00, 0, 0, 0, 0, 5'b11110, 1, 0, 0);
      vt[19] = mk(0, 5'h00, 0, 0, 0, 1, 5'b11100, 1, 0, 0);
      vt[20] = mk(0, 5'h00, 0, 0, 0, 1, 5'b11000, 1, 0, 0);
      vt[21] = mk(0, 5'h00, 0, 0, 0, 1, 5'b10001, 1, 0, 0);
      vt[22] = mk(0, 5'h00, 0, 0, 0, 1, 5'b00011, 0, 1, 0);
      vt[23] = mk(0, 5'h00, 0, 0, 0, 1, 5'b00011, 0, 0, 0);
      // Zero seed with start in the same cycle, sticky lockup, len=0, recovery
      vt[24] = mk(1, 5'b00000, 0, 1, 3, 1, 5'b11111, 0, 0, 1);
      vt[25] = mk(0, 5'h00, 0, 0, 0, 1, 5'b11111, 0, 0, 1);
      vt[26] = mk(0, 5'h00, 0, 1, 0, 1, 5'b11111, 0, 0, 1);
      vt[27] = mk(1, 5'b00001, 0, 0, 0, 1, 5'b00001, 0, 0, 0);
      // Load ignored in RUN; start accepted in the done cycle
      vt[28] = mk(0, 5'h00, 0, 1, 2, 0, 5'b00001, 1, 0, 0);
      vt[29] = mk(1, 5'b10101, 1, 1, 9, 0, 5'b00001, 1, 0, 0);
      vt[30] = mk(0, 5'h00, 0, 0, 0, 1, 5'b00010, 1, 0, 0);
      vt[31] = mk(0, 5'h00, 0, 0, 0, 1, 5'b00100, 0, 1, 0);
      vt[32] = mk(0, 5'h00, 1, 1, 1, 1, 5'b00100, 1, 0, 0);
      vt[33] = mk(0, 5'h00, 0, 0, 0, 1, 5'b01000, 0, 1, 0);

      // Reset defaults
      repeat (2) @(posedge clk);
      #1;
      check("rst_data", out_data, 5'b11111);
      check("rst_bit", out_bit, 1);
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_lockup", lockup, 0);
      check("rst_done", done, 0);
      rst = 1'b0;
      tick();
      check("idle_data", out_data, 5'b11111);

      for (int i = 0; i < 34; i++) begin
         load = vt[i].load; seed_in = vt[i].seed; mode = vt[i].mode;
         start = vt[i].start; len = vt[i].len; out_ready = vt[i].rdy;
         tick();
         check($sformatf("v%0d_data", i), out_data, vt[i].e_data);
         check($sformatf("v%0d_bit", i), out_bit, vt[i].e_data[4]);
         check($sformatf("v%0d_valid", i), out_valid, vt[i].e_valid);
         check($sformatf("v%0d_busy", i), busy, vt[i].e_valid);
         check($sformatf("v%0d_done", i), done, vt[i].e_done);
         check($sformatf("v%0d_lockup", i), lockup, vt[i].e_lock);
         check($sformatf("v%0d_wrap", i), wrap, 0);
      end

      // Full period: 31 Fibonacci steps from 11111 wrap exactly once, at the end
      load = 1; seed_in = 5'b11111; start = 0; mode = 0; out_ready = 1;
      tick();
      load = 0; start = 1; len = 31;
      tick();
      start = 0;
      exp_s = 5'b11111;
      wraps = 0;
      for (int i = 1; i <= 31; i++) begin
         tick();
         exp_s = fib_ref(exp_s);
         if (wrap) wraps++;
         if (i < 31) check($sformatf("per_data%0d", i), out_data, exp_s);
      end
      check("per_final", out_data, 5'b11111);
      check("per_wrap_now", wrap, 1);
      check("per_done", done, 1);
      check("per_valid", out_valid, 0);
      tick();
      if (wrap) wraps++;
      check("per_wrap_count", wraps, 1);

      // Reset mid-burst after word 10
      start = 1; len = 31;
      tick();
      start = 0;
      for (int i = 0; i < 10; i++) tick();
      check("mr_pre_data", out_data, 5'b01110);
      check("mr_pre_valid", out_valid, 1);
      rst = 1;
      #1;
      check("mr_valid", out_valid, 0);
      check("mr_busy", busy, 0);
      check("mr_data", out_data, 5'b11111);
      #2;
      rst = 0;
      wraps = 0;
      dones = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (wrap) wraps++;
         if (done) dones++;
      end
      check("mr_no_done", dones, 0);
      check("mr_no_wrap", wraps, 0);
      check("mr_idle_data", out_data, 5'b11111);
      check("mr_idle_valid", out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
